// File: rtl/frame_aligner_pkg.sv
// Shared constants and types for the frame aligner.
// Holds the default frame geometry, the sync header, the lock/unlock
// thresholds and the encoding of the lock state machine.
package frame_aligner_pkg;

    // Default frame length in bits
    localparam int DEF_FRAME_W = 40;

    // Width of the sync header at the top of each frame
    localparam int SYNC_W = 16;

    // Default sync header value
    localparam logic [SYNC_W-1:0] DEF_SYNC_PAT = 16'h3C5C;

    // Consecutive good headers needed to lock
    localparam int DEF_GOOD_N = 4;

    // Consecutive bad headers that drop lock
    localparam int DEF_BAD_N = 3;

    // Width of the internal good/bad header counters
    localparam int HDR_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_LOCKED  = 2'd2
    } lock_state_e;

endpackage

// File: rtl/frame_lock_sm.sv
// Frame lock state machine.
// Tracks SEARCH / CONFIRM / LOCKED from the header match result given at
// each frame boundary, and requests window slips while hunting.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   enable        : low forces SEARCH and clears the header counters
//   boundary      : current cycle completes a candidate frame
//   match         : candidate header equals the sync pattern
//   slip          : move the frame window by one bit (combinational)
//   lock_lost     : lock dropped at this boundary (combinational)
//   hdr_err       : header mismatch seen while locked (combinational)
//   in_locked     : state register currently holds LOCKED
//   locked        : registered lock indicator
module frame_lock_sm
    import frame_aligner_pkg::*;
#(
    parameter int GOOD_N = DEF_GOOD_N,
    parameter int BAD_N  = DEF_BAD_N
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic boundary,
    input  logic match,
    output logic slip,
    output logic lock_lost,
    output logic hdr_err,
    output logic in_locked,
    output logic locked
);

    lock_state_e            state_q, state_d;
    logic [HDR_CNT_W-1:0]   good_cnt_q, good_cnt_d;
    logic [HDR_CNT_W-1:0]   bad_cnt_q, bad_cnt_d;
    logic                   locked_q, locked_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_SEARCH;
            good_cnt_q <= '0;
            bad_cnt_q  <= '0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            good_cnt_q <= good_cnt_d;
            bad_cnt_q  <= bad_cnt_d;
            locked_q   <= locked_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        slip       = 1'b0;
        lock_lost  = 1'b0;
        hdr_err    = 1'b0;

        if (!enable) begin
            state_d    = ST_SEARCH;
            good_cnt_d = '0;
            bad_cnt_d  = '0;
        end else if (boundary) begin
            case (state_q)
                ST_SEARCH: begin
                    if (match) begin
                        state_d    = ST_CONFIRM;
                        good_cnt_d = HDR_CNT_W'(1);
                    end else begin
                        slip = 1'b1;
                    end
                end
                ST_CONFIRM: begin
                    if (match) begin
                        if (good_cnt_q + HDR_CNT_W'(1) >= HDR_CNT_W'(GOOD_N)) begin
                            state_d    = ST_LOCKED;
                            good_cnt_d = '0;
                            bad_cnt_d  = '0;
                        end else begin
                            good_cnt_d = good_cnt_q + HDR_CNT_W'(1);
                        end
                    end else begin
                        state_d    = ST_SEARCH;
                        good_cnt_d = '0;
                        slip       = 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (match) begin
                        bad_cnt_d = '0;
                    end else begin
                        hdr_err = 1'b1;
                        // Losing lock keeps the current phase: the header
                        // may reappear in the same place, so no slip here.
                        if (bad_cnt_q + HDR_CNT_W'(1) >= HDR_CNT_W'(BAD_N)) begin
                            state_d   = ST_SEARCH;
                            bad_cnt_d = '0;
                            lock_lost = 1'b1;
                        end else begin
                            bad_cnt_d = bad_cnt_q + HDR_CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d    = ST_SEARCH;
                    good_cnt_d = '0;
                    bad_cnt_d  = '0;
                end
            endcase
        end

        locked_d = (state_d == ST_LOCKED);
    end

    assign in_locked = (state_q == ST_LOCKED);
    assign locked    = locked_q;

endmodule

// File: rtl/frame_aligner.sv
// Frame aligner: finds the frame boundary in an aligned serial bit stream
// by hunting for a fixed sync header, then emits complete frames.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   enable         : low forces SEARCH and clears phase and slip count
//   din            : serial data, frame MSB first
//   frame_out      : last complete frame captured while locked
//   frame_valid    : one-cycle pulse when frame_out updates
//   locked         : high while the lock state machine is LOCKED
//   slip_count     : slips since the current search started, mod FRAME_W
//   hdr_err_count  : header mismatches while locked, saturating
module frame_aligner
    import frame_aligner_pkg::*;
#(
    parameter int                FRAME_W  = DEF_FRAME_W,
    parameter logic [SYNC_W-1:0] SYNC_PAT = DEF_SYNC_PAT,
    parameter int                GOOD_N   = DEF_GOOD_N,
    parameter int                BAD_N    = DEF_BAD_N
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               din,
    output logic [FRAME_W-1:0] frame_out,
    output logic               frame_valid,
    output logic               locked,
    output logic [5:0]         slip_count,
    output logic [15:0]        hdr_err_count
);

    localparam int CNT_W = $clog2(FRAME_W);

    logic [FRAME_W-1:0] sr_q, sr_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-1:0] frame_out_q, frame_out_d;
    logic               frame_valid_q, frame_valid_d;
    logic [5:0]         slip_count_q, slip_count_d;
    logic [15:0]        hdr_err_count_q, hdr_err_count_d;

    logic [FRAME_W-1:0] candidate;
    logic               boundary;
    logic               match;
    logic               slip;
    logic               lock_lost;
    logic               hdr_err;
    logic               in_locked;

    // The candidate includes the bit arriving this cycle, so a whole frame
    // can be judged on the same edge that completes it.
    assign candidate = {sr_q[FRAME_W-2:0], din};
    assign boundary  = (bit_cnt_q == CNT_W'(FRAME_W - 1));
    assign match     = (candidate[FRAME_W-1 -: SYNC_W] == SYNC_PAT);

    frame_lock_sm #(
        .GOOD_N (GOOD_N),
        .BAD_N  (BAD_N)
    ) u_lock_sm (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .boundary  (boundary),
        .match     (match),
        .slip      (slip),
        .lock_lost (lock_lost),
        .hdr_err   (hdr_err),
        .in_locked (in_locked),
        .locked    (locked)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q            <= '0;
            bit_cnt_q       <= '0;
            frame_out_q     <= '0;
            frame_valid_q   <= 1'b0;
            slip_count_q    <= '0;
            hdr_err_count_q <= '0;
        end else begin
            sr_q            <= sr_d;
            bit_cnt_q       <= bit_cnt_d;
            frame_out_q     <= frame_out_d;
            frame_valid_q   <= frame_valid_d;
            slip_count_q    <= slip_count_d;
            hdr_err_count_q <= hdr_err_count_d;
        end
    end

    // A slip reloads the bit counter with 1 rather than 0, making the next
    // window one bit shorter so it starts one bit earlier in the stream.
    always_comb begin
        sr_d            = candidate;
        bit_cnt_d       = bit_cnt_q + CNT_W'(1);
        frame_out_d     = frame_out_q;
        frame_valid_d   = 1'b0;
        slip_count_d    = slip_count_q;
        hdr_err_count_d = hdr_err_count_q;

        if (!enable) begin
            bit_cnt_d    = '0;
            slip_count_d = '0;
        end else begin
            if (boundary) begin
                bit_cnt_d = slip ? CNT_W'(1) : CNT_W'(0);
            end

            if (lock_lost) begin
                slip_count_d = '0;
            end else if (slip) begin
                slip_count_d = (slip_count_q == 6'(FRAME_W - 1)) ? 6'd0
                                                                 : slip_count_q + 6'd1;
            end

            if (boundary && in_locked) begin
                frame_out_d   = candidate;
                frame_valid_d = 1'b1;
            end

            if (hdr_err && (hdr_err_count_q != 16'hFFFF)) begin
                hdr_err_count_d = hdr_err_count_q + 16'd1;
            end
        end
    end

    assign frame_out     = frame_out_q;
    assign frame_valid   = frame_valid_q;
    assign slip_count    = slip_count_q;
    assign hdr_err_count = hdr_err_count_q;

endmodule
